// File: rtl/prog_clk_divider_pkg.sv
// Shared definitions for the programmable clock divider.
//   MODE_TOGGLE / MODE_PULSE : output mode encodings (0 / 1)
//   CH_W                     : width of the load channel index
//   ch_in_range()            : true when a load index addresses a real channel
package clk_div_pkg;

    localparam int CH_W = 4;

    typedef enum logic {
        MODE_TOGGLE = 1'b0,
        MODE_PULSE  = 1'b1
    } mode_e;

    function automatic logic ch_in_range(input logic [CH_W-1:0] ch, input int n_ch);
        return (int'(32'(ch)) < n_ch);
    endfunction

endpackage

// File: rtl/prog_clk_divider_if.sv
// Divisor-load bus of the programmable clock divider.
//   ld_valid/ld_ch/ld_div/ld_mode : load request from the master
//   ld_ready                      : slave can take the load this cycle
//   ld_err                        : one-cycle flag for an accepted out-of-range index
interface prog_clk_divider_if
    import clk_div_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic            ld_valid;
    logic [CH_W-1:0] ld_ch;
    logic [CNT_W-1:0] ld_div;
    logic            ld_mode;
    logic            ld_ready;
    logic            ld_err;

    modport master (output ld_valid, ld_ch, ld_div, ld_mode, input ld_ready, ld_err);
    modport slave  (input ld_valid, ld_ch, ld_div, ld_mode, output ld_ready, ld_err);
endinterface

// File: rtl/prog_clk_divider_channel.sv
// One divider channel: counter, active settings and a one-entry pending slot.
//   clkin, reset : clock, synchronous active-high reset
//   en_i         : run enable
//   ld_we_i      : write the pending slot (already qualified by the top)
//   ld_div_i     : new terminal count
//   ld_mode_i    : new mode (0 toggle, 1 pulse)
//   pend_v_o     : pending slot occupied
//   clkout_o     : divided output
//   tick_o       : terminal-count pulse
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int DEF_DIV = 50
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic             en_i,
    input  logic             ld_we_i,
    input  logic [CNT_W-1:0] ld_div_i,
    input  logic             ld_mode_i,
    output logic             pend_v_o,
    output logic             clkout_o,
    output logic             tick_o
);

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] div_q, div_d;
    mode_e            mode_q, mode_d;
    logic             clk_q, clk_d;
    logic             pend_v_q, pend_v_d;
    logic [CNT_W-1:0] pend_div_q, pend_div_d;
    mode_e            pend_mode_q, pend_mode_d;
    logic             event_s;

    // Terminal count; suppressed during reset so no event fires in that cycle.
    assign event_s = ~reset & en_i & (count_q == div_q);

    // Next-state: counting, pending-load application, output toggling.
    always_comb begin
        count_d     = count_q;
        div_d       = div_q;
        mode_d      = mode_q;
        clk_d       = clk_q;
        pend_v_d    = pend_v_q;
        pend_div_d  = pend_div_q;
        pend_mode_d = pend_mode_q;
        if (!en_i) begin
            // Idle channel: hold at zero and take any pending load at once.
            count_d = {CNT_W{1'b0}};
            clk_d   = 1'b0;
            if (pend_v_q) begin
                div_d    = pend_div_q;
                mode_d   = pend_mode_q;
                pend_v_d = 1'b0;
            end else begin
                pend_v_d = pend_v_q;
            end
        end else if (event_s) begin
            count_d = {CNT_W{1'b0}};
            if (pend_v_q) begin
                div_d    = pend_div_q;
                mode_d   = pend_mode_q;
                pend_v_d = 1'b0;
                // A mode switch restarts the output low.
                if ((pend_mode_q != mode_q) || (pend_mode_q == MODE_PULSE)) begin
                    clk_d = 1'b0;
                end else begin
                    clk_d = ~clk_q;
                end
            end else if (mode_q == MODE_TOGGLE) begin
                clk_d = ~clk_q;
            end else begin
                clk_d = 1'b0;
            end
        end else begin
            count_d = count_q + CNT_W'(1);
        end
        // The top only raises ld_we_i while the slot is empty, so this never
        // collides with the slot being consumed above.
        if (ld_we_i) begin
            pend_v_d    = 1'b1;
            pend_div_d  = ld_div_i;
            pend_mode_d = mode_e'(ld_mode_i);
        end else begin
            pend_div_d  = pend_div_d;
        end
    end

    // State registers with synchronous reset to the default divisor.
    always_ff @(posedge clkin) begin
        if (reset) begin
            count_q     <= {CNT_W{1'b0}};
            div_q       <= CNT_W'(DEF_DIV);
            mode_q      <= MODE_TOGGLE;
            clk_q       <= 1'b0;
            pend_v_q    <= 1'b0;
            pend_div_q  <= {CNT_W{1'b0}};
            pend_mode_q <= MODE_TOGGLE;
        end else begin
            count_q     <= count_d;
            div_q       <= div_d;
            mode_q      <= mode_d;
            clk_q       <= clk_d;
            pend_v_q    <= pend_v_d;
            pend_div_q  <= pend_div_d;
            pend_mode_q <= pend_mode_d;
        end
    end

    // Output select: pulse mode mirrors the tick, toggle mode the flop.
    always_comb begin
        tick_o   = event_s;
        pend_v_o = pend_v_q;
        if (mode_q == MODE_PULSE) begin
            clkout_o = event_s;
        end else begin
            clkout_o = clk_q & en_i & ~reset;
        end
    end

endmodule

// File: rtl/prog_clk_divider.sv
// Programmable multi-channel clock divider (top): load decode and ld_err only;
// all divider state lives in the generated channels.
//   clkin, reset : clock, synchronous active-high reset
//   en           : per-channel run enable
//   bus          : divisor-load interface (slave side)
//   clkout       : divided output per channel
//   tick         : terminal-count pulse per channel
module prog_clk_divider
    import clk_div_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int CNT_W   = 16,
    parameter int DEF_DIV = 50
) (
    input  logic              clkin,
    input  logic              reset,
    input  logic [N_CH-1:0]   en,
    prog_clk_divider_if.slave bus,
    output logic [N_CH-1:0]   clkout,
    output logic [N_CH-1:0]   tick
);

    logic [N_CH-1:0] pend_v_s;
    logic [N_CH-1:0] ld_we_s;
    logic            ld_ready_s;
    logic            ld_err_q, ld_err_d;

    // Load decode: ready reflects the addressed slot; out-of-range reads ready.
    always_comb begin
        ld_ready_s = 1'b1;
        ld_we_s    = {N_CH{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            if (bus.ld_ch == CH_W'(i)) begin
                ld_ready_s = ~pend_v_s[i];
                ld_we_s[i] = bus.ld_valid & ~pend_v_s[i] & ~reset;
            end else begin
                ld_we_s[i] = 1'b0;
            end
        end
        if (reset) begin
            ld_ready_s = 1'b1;
        end else begin
            ld_ready_s = ld_ready_s;
        end
        ld_err_d = bus.ld_valid & ~ch_in_range(bus.ld_ch, N_CH);
    end

    assign bus.ld_ready = ld_ready_s;
    assign bus.ld_err   = ld_err_q & ~reset;

    // Error flag: one cycle after an out-of-range load is taken.
    always_ff @(posedge clkin) begin
        if (reset) begin
            ld_err_q <= 1'b0;
        end else begin
            ld_err_q <= ld_err_d;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        clk_div_channel #(
            .CNT_W  (CNT_W),
            .DEF_DIV(DEF_DIV)
        ) u_ch (
            .clkin    (clkin),
            .reset    (reset),
            .en_i     (en[g]),
            .ld_we_i  (ld_we_s[g]),
            .ld_div_i (bus.ld_div),
            .ld_mode_i(bus.ld_mode),
            .pend_v_o (pend_v_s[g]),
            .clkout_o (clkout[g]),
            .tick_o   (tick[g])
        );
    end

endmodule

// File: tb/tb_prog_clk_divider.sv
// Self-checking bench for prog_clk_divider. A per-channel closed-form model
// (start window, divisor, mode, initial clkout) yields the expected tick/clkout
// of each window; expectations are queued when a window is driven and popped
// when the DUT outputs are sampled on the falling edge.
module tb_prog_clk_divider;
    import clk_div_pkg::*;

    localparam int N_CH    = 4;
    localparam int CNT_W   = 16;
    localparam int DEF_DIV = 50;

    logic            clkin = 1'b0;
    logic            reset;
    logic [N_CH-1:0] en;
    logic [N_CH-1:0] clkout;
    logic [N_CH-1:0] tick;

    prog_clk_divider_if #(.CNT_W(CNT_W)) bus ();

    prog_clk_divider #(.N_CH(N_CH), .CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) dut (
        .clkin (clkin),
        .reset (reset),
        .en    (en),
        .bus   (bus),
        .clkout(clkout),
        .tick  (tick)
    );

    always #5 clkin = ~clkin;

    typedef struct {
        logic [N_CH-1:0] tk;
        logic [N_CH-1:0] ck;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc_n   = 0;

    int   m_div[N_CH];
    int   m_start[N_CH];
    logic m_mode[N_CH];
    logic m_clk0[N_CH];
    logic m_en[N_CH];
    logic m_rst;

    // Expected {tick, clkout} of channel ch in window t.
    function automatic logic [1:0] exp_ch(input int ch, input int t);
        int   ph;
        logic tk, ck;
        if (m_rst || !m_en[ch]) return 2'b00;
        ph = t - m_start[ch];
        tk = ((ph % (m_div[ch] + 1)) == m_div[ch]);
        if (m_mode[ch]) ck = tk;
        else            ck = m_clk0[ch] ^ (((ph / (m_div[ch] + 1)) % 2) == 1);
        return {tk, ck};
    endfunction

    function automatic int next_event(input int ch, input int t);
        int r;
        r = (t - m_start[ch]) % (m_div[ch] + 1);
        return t + (m_div[ch] - r);
    endfunction

    task automatic set_model(input int ch, input int start, input int dv, input logic md, input logic c0);
        m_start[ch] = start;
        m_div[ch]   = dv;
        m_mode[ch]  = md;
        m_clk0[ch]  = c0;
        m_en[ch]    = 1'b1;
    endtask

    task automatic sb_push();
        exp_t       e;
        logic [1:0] r;
        for (int ch = 0; ch < N_CH; ch++) begin
            r        = exp_ch(ch, cyc_n);
            e.tk[ch] = r[1];
            e.ck[ch] = r[0];
        end
        sb_q.push_back(e);
    endtask

    task automatic next_window();
        @(posedge clkin);
        #1;
        cyc_n++;
    endtask

    task automatic test_reset();
        exp_t e;
        reset = 1'b1; en = '0;
        bus.ld_valid = 1'b1; bus.ld_ch = 4'd9; bus.ld_div = 16'd0; bus.ld_mode = 1'b0;
        repeat (2) @(posedge clkin);
        #1;
        bus.ld_valid = 1'b0;
        @(negedge clkin);
        n_total++;
        if (tick !== 4'b0000 || clkout !== 4'b0000) $display("FAIL reset_outputs tick=%b clkout=%b required 0000/0000", tick, clkout);
        else n_pass++;
        n_total++;
        if (bus.ld_ready !== 1'b1 || bus.ld_err !== 1'b0) $display("FAIL reset_ld ready=%b err=%b required 1/0", bus.ld_ready, bus.ld_err);
        else n_pass++;
        @(posedge clkin);
        #1;
        reset = 1'b0; en = 4'hF; cyc_n = 0; m_rst = 1'b0;
        for (int ch = 0; ch < N_CH; ch++) set_model(ch, 0, DEF_DIV, 1'b0, 1'b0);
        while (cyc_n < 210) begin
            sb_push();
            @(negedge clkin);
            e = sb_q.pop_front();
            n_total++;
            if (tick !== e.tk || clkout !== e.ck)
                $display("FAIL reset_run cyc=%0d tick=%b clkout=%b required %b/%b", cyc_n, tick, clkout, e.tk, e.ck);
            else n_pass++;
            next_window();
        end
    endtask

    task automatic test_deferred();
        exp_t e;
        int   t1, ev, stop;
        logic rdy;
        t1   = cyc_n + ((20 - ((cyc_n - m_start[1]) % 51) + 51) % 51);
        ev   = next_event(1, t1 + 1);
        stop = ev + 21;
        bus.ld_ch = 4'd1; bus.ld_div = 16'd3; bus.ld_mode = 1'b1;
        while (cyc_n < stop) begin
            bus.ld_valid = (cyc_n == t1);
            if (cyc_n == ev + 1) set_model(1, ev + 1, 3, 1'b1, 1'b0);
            sb_push();
            @(negedge clkin);
            e = sb_q.pop_front();
            n_total++;
            if (tick !== e.tk || clkout !== e.ck)
                $display("FAIL deferred cyc=%0d tick=%b clkout=%b required %b/%b", cyc_n, tick, clkout, e.tk, e.ck);
            else n_pass++;
            if (cyc_n >= t1) begin
                rdy = (cyc_n == t1) || (cyc_n > ev);
                n_total++;
                if (bus.ld_ready !== rdy) $display("FAIL deferred_ready cyc=%0d ready=%b required %b", cyc_n, bus.ld_ready, rdy);
                else n_pass++;
            end
            next_window();
        end
        bus.ld_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   a, ev, ev2, stop;
        logic rdy;
        a    = cyc_n + 1;
        ev   = next_event(1, a + 1);
        ev2  = ev + 6;
        stop = ev2 + 21;
        bus.ld_ch = 4'd1; bus.ld_mode = 1'b1;
        while (cyc_n < stop) begin
            bus.ld_valid = (cyc_n >= a) && (cyc_n <= ev + 1);
            bus.ld_div   = (cyc_n == a) ? 16'd5 : 16'd7;
            if (cyc_n == ev + 1)  set_model(1, ev + 1, 5, 1'b1, 1'b0);
            if (cyc_n == ev2 + 1) set_model(1, ev2 + 1, 7, 1'b1, 1'b0);
            sb_push();
            @(negedge clkin);
            e = sb_q.pop_front();
            n_total++;
            if (tick !== e.tk || clkout !== e.ck)
                $display("FAIL b2b cyc=%0d tick=%b clkout=%b required %b/%b", cyc_n, tick, clkout, e.tk, e.ck);
            else n_pass++;
            if (cyc_n >= a) begin
                rdy = (cyc_n == a) || (cyc_n == ev + 1) || (cyc_n > ev2);
                n_total++;
                if (bus.ld_ready !== rdy) $display("FAIL b2b_ready cyc=%0d ready=%b required %b", cyc_n, bus.ld_ready, rdy);
                else n_pass++;
            end
            next_window();
        end
        bus.ld_valid = 1'b0;
    endtask

    task automatic test_boundary();
        exp_t       e;
        int         a, ev, b, stop;
        logic [1:0] r;
        a    = cyc_n;
        ev   = next_event(1, a + 1);
        b    = ev + 6;
        stop = b + 17;
        bus.ld_ch = 4'd1; bus.ld_mode = 1'b0;
        while (cyc_n < stop) begin
            bus.ld_valid = (cyc_n == a) || (cyc_n == b);
            bus.ld_div   = (cyc_n == a) ? 16'd0 : 16'd2;
            if (cyc_n == ev + 1) set_model(1, ev + 1, 0, 1'b0, 1'b0);
            if (cyc_n == b + 2) begin
                r = exp_ch(1, b + 1);
                set_model(1, b + 2, 2, 1'b0, ~r[0]);
            end
            sb_push();
            @(negedge clkin);
            e = sb_q.pop_front();
            n_total++;
            if (tick !== e.tk || clkout !== e.ck)
                $display("FAIL boundary cyc=%0d tick=%b clkout=%b required %b/%b", cyc_n, tick, clkout, e.tk, e.ck);
            else n_pass++;
            if (cyc_n > ev && cyc_n <= b + 1) begin
                n_total++;
                if (tick[1] !== 1'b1) $display("FAIL div0_tick cyc=%0d tick1=%b required 1", cyc_n, tick[1]);
                else n_pass++;
            end
            next_window();
        end
        bus.ld_valid = 1'b0;
    endtask

    task automatic test_disable_range();
        exp_t e;
        int   w0;
        w0 = cyc_n;
        while (cyc_n < w0 + 30) begin
            en[2] = !(cyc_n >= w0 && cyc_n < w0 + 3);
            if (cyc_n == w0) m_en[2] = 1'b0;
            if (cyc_n == w0 + 3) set_model(2, w0 + 3, 4, 1'b0, 1'b0);
            bus.ld_valid = (cyc_n == w0) || (cyc_n == w0 + 5);
            bus.ld_ch    = (cyc_n >= w0 + 5) ? 4'd9 : 4'd2;
            bus.ld_div   = (cyc_n == w0) ? 16'd4 : 16'd1;
            bus.ld_mode  = (cyc_n == w0 + 5);
            sb_push();
            @(negedge clkin);
            e = sb_q.pop_front();
            n_total++;
            if (tick !== e.tk || clkout !== e.ck)
                $display("FAIL disable cyc=%0d tick=%b clkout=%b required %b/%b", cyc_n, tick, clkout, e.tk, e.ck);
            else n_pass++;
            if (cyc_n <= w0 + 2) begin
                n_total++;
                if (bus.ld_ready !== (cyc_n != w0 + 1)) $display("FAIL dis_ready cyc=%0d ready=%b", cyc_n, bus.ld_ready);
                else n_pass++;
            end
            if (cyc_n >= w0 + 5 && cyc_n <= w0 + 7) begin
                n_total++;
                if (bus.ld_err !== (cyc_n == w0 + 6) || bus.ld_ready !== 1'b1)
                    $display("FAIL range_err cyc=%0d err=%b ready=%b required %b/1", cyc_n, bus.ld_err, bus.ld_ready, (cyc_n == w0 + 6));
                else n_pass++;
            end
            next_window();
        end
        bus.ld_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   t10, t20, stop;
        logic rdy;
        t10  = cyc_n + ((10 - ((cyc_n - m_start[0]) % 51) + 51) % 51);
        t20  = t10 + 10;
        stop = t20 + 111;
        bus.ld_ch = 4'd0; bus.ld_div = 16'd9; bus.ld_mode = 1'b1;
        while (cyc_n < stop) begin
            bus.ld_valid = (cyc_n == t10);
            reset        = (cyc_n == t20);
            m_rst        = (cyc_n == t20);
            if (cyc_n == t20 + 1)
                for (int ch = 0; ch < N_CH; ch++) set_model(ch, t20 + 1, DEF_DIV, 1'b0, 1'b0);
            sb_push();
            @(negedge clkin);
            e = sb_q.pop_front();
            n_total++;
            if (tick !== e.tk || clkout !== e.ck)
                $display("FAIL reset_mid cyc=%0d tick=%b clkout=%b required %b/%b", cyc_n, tick, clkout, e.tk, e.ck);
            else n_pass++;
            if (cyc_n >= t10 && cyc_n <= t20 + 2) begin
                rdy = !(cyc_n > t10 && cyc_n < t20);
                n_total++;
                if (bus.ld_ready !== rdy || bus.ld_err !== 1'b0)
                    $display("FAIL reset_mid_ld cyc=%0d ready=%b err=%b required %b/0", cyc_n, bus.ld_ready, bus.ld_err, rdy);
                else n_pass++;
            end
            next_window();
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_deferred();
        test_back_to_back();
        test_boundary();
        test_disable_range();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
